// File: rtl/rv32i_types.sv
// Shared types for the cache-subsystem line arbiter: line geometry, arbiter
// state encoding and line-address helpers.
package rv32i_types;

  localparam logic [31:0]  LINE_BYTES       = 32'd32;
  localparam int unsigned  LINE_OFFSET_BITS = 5;

  typedef logic [255:0] line_t;
  typedef logic [31-LINE_OFFSET_BITS:0] line_tag_t;

  typedef enum logic [2:0] {
    StIdle,
    StServeI,
    StServeD,
    StPfHit,
    StPrefetch
  } line_arb_state_t;

  typedef enum logic {
    GntI,
    GntD
  } grant_t;

  // Clear the byte-offset bits so the adaptor always sees a line address.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~(LINE_BYTES - 32'd1);
  endfunction

  function automatic line_tag_t line_tag(input logic [31:0] addr);
    return line_tag_t'(addr >> LINE_OFFSET_BITS);
  endfunction

endpackage

// File: rtl/prefetch_buffer.sv
// One-line next-line prefetch buffer: tag, valid and data registers with a
// lookup compare and a tag-matched invalidate port.
module prefetch_buffer
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  line_tag_t load_tag,
  input  line_t     load_data,
  input  logic      inval,
  input  line_tag_t inval_tag,
  input  line_tag_t lookup_tag,
  output logic      hit,
  output logic      valid,
  output line_tag_t tag,
  output line_t     data
);

  logic      valid_q;
  line_tag_t tag_q;
  line_t     data_q;

  // Fill on a completed prefetch; drop the line when the dcache overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      tag_q   <= load_tag;
      data_q  <= load_data;
    end else if (inval && (inval_tag == tag_q)) begin
      valid_q <= 1'b0;
    end
  end

  // Lookup compare and register views.
  always_comb begin
    hit   = valid_q && (lookup_tag == tag_q);
    valid = valid_q;
    tag   = tag_q;
    data  = data_q;
  end

endmodule

// File: rtl/line_prefetch_arbiter.sv
// Round-robin arbiter sharing the cacheline adaptor between icache and dcache.
// With PREFETCH_EN defined, an icache miss on line N is followed by a
// non-preemptible prefetch of line N+1 into a one-line buffer that can serve
// a later icache request without a memory transaction.
module line_prefetch_arbiter
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_line_read,
  input  logic [31:0] i_line_address,
  output line_t       i_line_rdata,
  output logic        i_line_resp,
  input  logic        d_line_read,
  input  logic        d_line_write,
  input  logic [31:0] d_line_address,
  input  line_t       d_line_wdata,
  output line_t       d_line_rdata,
  output logic        d_line_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output line_t       mem_wdata,
  input  line_t       mem_rdata,
  input  logic        mem_resp
);

  line_arb_state_t state_q, state_d;
  grant_t          last_grant_q, last_grant_d;
  logic [31:0]     addr_q, addr_d;
  line_t           wdata_q, wdata_d;
  logic            write_q, write_d;
  logic            d_req;

`ifdef PREFETCH_EN
  logic        buf_load;
  logic        buf_inval;
  logic        buf_hit;
  logic        buf_valid;
  line_tag_t   buf_tag;
  line_t       buf_data;
  logic        pf_hit_enter;
  logic [31:0] pf_hits_q;

  prefetch_buffer u_pf_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_tag   (line_tag(addr_q)),
    .load_data  (mem_rdata),
    .inval      (buf_inval),
    .inval_tag  (line_tag(d_line_address)),
    .lookup_tag (line_tag(i_line_address)),
    .hit        (buf_hit),
    .valid      (buf_valid),
    .tag        (buf_tag),
    .data       (buf_data)
  );

  // Count prefetch-buffer hits, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_hits_q <= '0;
    end else if (pf_hit_enter && (pf_hits_q != '1)) begin
      pf_hits_q <= pf_hits_q + 32'd1;
    end
  end
`endif

  assign d_req = d_line_read | d_line_write;

  // State, round-robin history and latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GntD;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  // Arbitration, next-state and adaptor/cache-side outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_wdata    = '0;
    i_line_resp  = 1'b0;
    d_line_resp  = 1'b0;
    i_line_rdata = mem_rdata;
    d_line_rdata = mem_rdata;
`ifdef PREFETCH_EN
    buf_load     = 1'b0;
    buf_inval    = 1'b0;
    pf_hit_enter = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef PREFETCH_EN
        // A buffer hit bypasses arbitration and leaves last_grant alone.
        if (i_line_read && buf_hit) begin
          state_d      = StPfHit;
          pf_hit_enter = 1'b1;
        end else
`endif
        if (i_line_read && (!d_req || (last_grant_q == GntD))) begin
          state_d = StServeI;
          addr_d  = line_align(i_line_address);
          write_d = 1'b0;
        end else if (d_req) begin
          state_d = StServeD;
          addr_d  = line_align(d_line_address);
          wdata_d = d_line_wdata;
          write_d = d_line_write;
`ifdef PREFETCH_EN
          buf_inval = d_line_write;
`endif
        end
      end

      StServeI: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
        if (mem_resp) begin
          i_line_resp  = 1'b1;
          last_grant_d = GntI;
          state_d      = StIdle;
`ifdef PREFETCH_EN
          if (!(buf_valid && (buf_tag == line_tag(addr_q + LINE_BYTES)))) begin
            state_d = StPrefetch;
            addr_d  = addr_q + LINE_BYTES;
          end
`endif
        end
      end

      StServeD: begin
        mem_read    = ~write_q;
        mem_write   = write_q;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        if (mem_resp) begin
          d_line_resp  = 1'b1;
          last_grant_d = GntD;
          state_d      = StIdle;
        end
      end

`ifdef PREFETCH_EN
      StPfHit: begin
        i_line_resp  = 1'b1;
        i_line_rdata = buf_data;
        state_d      = StIdle;
      end

      StPrefetch: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
        if (mem_resp) begin
          buf_load = 1'b1;
          state_d  = StIdle;
          // An icache request already waiting on this line completes with the fill.
          if (i_line_read && (line_tag(i_line_address) == line_tag(addr_q))) begin
            i_line_resp = 1'b1;
          end
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_line_prefetch_arbiter.sv
// Directed bench for line_prefetch_arbiter with a fixed-latency adaptor model.
// Expectations follow the PREFETCH_EN setting of the build.
module tb_line_prefetch_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_line_read;
  logic [31:0]  i_line_address;
  logic [255:0] i_line_rdata;
  logic         i_line_resp;
  logic         d_line_read;
  logic         d_line_write;
  logic [31:0]  d_line_address;
  logic [255:0] d_line_wdata;
  logic [255:0] d_line_rdata;
  logic         d_line_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_resp;

  int total = 0;
  int bad   = 0;
  int txn_count = 0;
  int ad_cnt;
  localparam int AdLat = 4;

  line_prefetch_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_line_read    (i_line_read),
    .i_line_address (i_line_address),
    .i_line_rdata   (i_line_rdata),
    .i_line_resp    (i_line_resp),
    .d_line_read    (d_line_read),
    .d_line_write   (d_line_write),
    .d_line_address (d_line_address),
    .d_line_wdata   (d_line_wdata),
    .d_line_rdata   (d_line_rdata),
    .d_line_resp    (d_line_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // Adaptor: responds AdLat cycles after it first sees a request.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_cnt    <= 0;
      mem_resp  <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_resp <= 1'b0;
      if ((mem_read || mem_write) && !mem_resp) begin
        if (ad_cnt == AdLat - 1) begin
          mem_resp  <= 1'b1;
          mem_rdata <= line_of(mem_address);
          ad_cnt    <= 0;
          txn_count <= txn_count + 1;
        end else begin
          ad_cnt <= ad_cnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_line_read = 1'b0; i_line_address = '0;
    d_line_read = 1'b0; d_line_write = 1'b0; d_line_address = '0; d_line_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for the next adaptor transaction; returns in its mem_resp cycle.
  task automatic next_txn(output logic [31:0] a, output logic we, output logic [255:0] wd);
    int n;
    n = 0;
    tick();
    while (!(mem_read || mem_write) && n < 40) begin tick(); n++; end
    chk("txn_start", 256'(mem_read || mem_write), 256'd1);
    a = mem_address; we = mem_write; wd = mem_wdata;
    n = 0;
    while (!mem_resp && n < 40) begin tick(); n++; end
    chk("txn_resp", 256'(mem_resp), 256'd1);
  endtask

  logic [31:0]  a;
  logic         we;
  logic [255:0] wd;
  int           n;
  int           base;

  initial begin
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_mem_read", 256'(mem_read), 256'd0);
    chk("rst_mem_write", 256'(mem_write), 256'd0);
    chk("rst_mem_address", 256'(mem_address), 256'd0);
    chk("rst_mem_wdata", mem_wdata, 256'd0);
    chk("rst_resps", 256'({i_line_resp, d_line_resp}), 256'd0);
`ifdef PREFETCH_EN
    chk("rst_buf_valid", 256'(dut.u_pf_buf.valid_q), 256'd0);
    chk("rst_pf_hits", 256'(dut.pf_hits_q), 256'd0);
`endif
    tick();
    rst = 1'b0;

    // Icache miss at 0x1000, then next-line prefetch.
    base = txn_count;
    i_line_read = 1'b1; i_line_address = 32'h0000_1004;
    tick();
    chk("miss_grant_read", 256'(mem_read), 256'd1);
    chk("miss_grant_addr", 256'(mem_address), 256'h1000);
    n = 0;
    while (!i_line_resp && n < 20) begin tick(); n++; end
    chk("miss_latency", 256'(n), 256'(AdLat));
    chk("miss_rdata", i_line_rdata, line_of(32'h1000));
    i_line_read = 1'b0;
    tick();
`ifdef PREFETCH_EN
    chk("pf_read", 256'(mem_read), 256'd1);
    chk("pf_addr", 256'(mem_address), 256'h1020);
`else
    chk("no_pf_read", 256'(mem_read), 256'd0);
`endif
    n = 0;
    while (mem_read && n < 20) begin tick(); n++; end
`ifdef PREFETCH_EN
    chk("pf_buf_valid", 256'(dut.u_pf_buf.valid_q), 256'd1);
    chk("pf_txns", 256'(txn_count - base), 256'd2);

    // Buffered line served without memory.
    i_line_read = 1'b1; i_line_address = 32'h0000_1020;
    tick();
    chk("hit_resp", 256'(i_line_resp), 256'd1);
    chk("hit_rdata", i_line_rdata, line_of(32'h1020));
    chk("hit_no_mem", 256'(mem_read), 256'd0);
    chk("hit_count", 256'(dut.pf_hits_q), 256'd1);
    i_line_read = 1'b0;
    tick();
    chk("hit_resp_single", 256'(i_line_resp), 256'd0);
    chk("hit_buf_kept", 256'(dut.u_pf_buf.valid_q), 256'd1);
    chk("hit_txns", 256'(txn_count - base), 256'd2);
`else
    chk("plain_txns", 256'(txn_count - base), 256'd1);
`endif

    // Ties from reset alternate, I first.
    do_reset();
    i_line_read = 1'b1; i_line_address = 32'h2000;
    d_line_read = 1'b1; d_line_address = 32'h3000;
    next_txn(a, we, wd);
    chk("tie1_addr", 256'(a), 256'h2000);
    chk("tie1_iresp", 256'({i_line_resp, d_line_resp}), 256'b10);
    chk("tie1_rdata", i_line_rdata, line_of(32'h2000));
    i_line_address = 32'h4000;
`ifdef PREFETCH_EN
    next_txn(a, we, wd);
    chk("tie1_pf_addr", 256'(a), 256'h2020);
    chk("tie1_pf_noresp", 256'({i_line_resp, d_line_resp}), 256'b00);
`endif
    next_txn(a, we, wd);
    chk("tie2_addr", 256'(a), 256'h3000);
    chk("tie2_dresp", 256'({i_line_resp, d_line_resp}), 256'b01);
    chk("tie2_rdata", d_line_rdata, line_of(32'h3000));
    d_line_read = 1'b0;
    next_txn(a, we, wd);
    chk("tie3_addr", 256'(a), 256'h4000);
    d_line_read = 1'b1; d_line_address = 32'h5000;
    i_line_address = 32'h6000;
`ifdef PREFETCH_EN
    next_txn(a, we, wd);
    chk("tie3_pf_addr", 256'(a), 256'h4020);
`endif
    next_txn(a, we, wd);
    chk("tie4_addr", 256'(a), 256'h5000);
    d_line_read = 1'b0;
    next_txn(a, we, wd);
    chk("tie5_addr", 256'(a), 256'h6000);
    i_line_read = 1'b0;
`ifdef PREFETCH_EN
    next_txn(a, we, wd);
    chk("tie5_pf_addr", 256'(a), 256'h6020);
`endif

    // Icache asks for the line being prefetched: one transaction serves it.
    do_reset();
    base = txn_count;
    i_line_read = 1'b1; i_line_address = 32'h1000;
    next_txn(a, we, wd);
    i_line_address = 32'h1020;
    next_txn(a, we, wd);
    chk("inflight_addr", 256'(a), 256'h1020);
    chk("inflight_resp", 256'({mem_resp, i_line_resp}), 256'b11);
    chk("inflight_rdata", i_line_rdata, line_of(32'h1020));
    i_line_read = 1'b0;
    tick(); tick(); tick();
    chk("inflight_idle", 256'(mem_read), 256'd0);
    chk("inflight_txns", 256'(txn_count - base), 256'd2);

    // Dcache writeback to the buffered line invalidates it.
    d_line_write = 1'b1; d_line_address = 32'h1020; d_line_wdata = {8{32'hCAFE_F00D}};
    next_txn(a, we, wd);
    chk("dwr_addr", 256'(a), 256'h1020);
    chk("dwr_we", 256'(we), 256'd1);
    chk("dwr_wdata", wd, {8{32'hCAFE_F00D}});
    chk("dwr_dresp", 256'(d_line_resp), 256'd1);
`ifdef PREFETCH_EN
    chk("dwr_inval", 256'(dut.u_pf_buf.valid_q), 256'd0);
`endif
    d_line_write = 1'b0;
    i_line_read = 1'b1; i_line_address = 32'h1020;
    next_txn(a, we, wd);
    chk("refetch_addr", 256'({we, a}), 256'h1020);
    chk("refetch_resp", 256'(i_line_resp), 256'd1);
    i_line_read = 1'b0;
`ifdef PREFETCH_EN
    chk("refetch_no_hit", 256'(dut.pf_hits_q), 256'd0);
    next_txn(a, we, wd);
    chk("refetch_pf_addr", 256'(a), 256'h1040);
`endif

    // Prefetch address wraps at the top of memory.
    i_line_read = 1'b1; i_line_address = 32'hFFFF_FFE0;
    next_txn(a, we, wd);
    chk("wrap_miss_addr", 256'(a), 256'hFFFF_FFE0);
    i_line_read = 1'b0;
`ifdef PREFETCH_EN
    next_txn(a, we, wd);
    chk("wrap_pf_addr", 256'(a), 256'h0);
`endif
    tick();

    // Reset mid writeback clears outputs at once.
    d_line_write = 1'b1; d_line_address = 32'h7000; d_line_wdata = {8{32'h1234_5678}};
    tick(); tick();
    chk("midrst_pre_write", 256'(mem_write), 256'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem", 256'({mem_read, mem_write}), 256'd0);
    chk("midrst_addr", 256'(mem_address), 256'd0);
    chk("midrst_wdata", mem_wdata, 256'd0);
    chk("midrst_resp", 256'({i_line_resp, d_line_resp}), 256'd0);
`ifdef PREFETCH_EN
    chk("midrst_buf", 256'(dut.u_pf_buf.valid_q), 256'd0);
`endif
    d_line_write = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
